// File: rtl/alu_sequencer_pkg.sv
// Shared types and instruction field layout for the ALU sequencer and its datapath.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    REG_READ  = 2'b00,
    REG_WRITE = 2'b01,
    ADD       = 2'b10
  } ALUOp;

  typedef enum logic [1:0] {
    SEQ_LOADI = 2'b00,
    SEQ_ADD   = 2'b01,
    SEQ_READ  = 2'b10,
    SEQ_NOP   = 2'b11
  } SeqKind;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ADD_WAIT,
    S_READ_WAIT
  } SeqState;

  localparam int INSTR_W  = 16;
  localparam int REG_AW   = 3;
  localparam int DATA_W   = 8;
  localparam int KIND_LSB = 14;
  localparam int RD_LSB   = 11;
  localparam int RA_LSB   = 8;
  localparam int RB_LSB   = 5;
  localparam int IMM_LSB  = 0;

  function automatic SeqKind instr_kind(input logic [INSTR_W-1:0] instr);
    return SeqKind'(instr[KIND_LSB +: 2]);
  endfunction

endpackage

// File: rtl/alu_sequencer_seq_latency_counter.sv
// Down-counter timing the sequencer wait states: load on entry, decrement to zero.
module seq_latency_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Micro-instruction front end for alu_registers; one instruction in flight, registered datapath controls.
// Optional ALU_SEQ_PERF_EN adds saturating accepted-instruction and stall counters.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int ADD_LATENCY  = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [REG_AW-1:0]  alu_addr_a,
  output logic [REG_AW-1:0]  alu_addr_b,
  output logic [REG_AW-1:0]  alu_addr_r,
  output logic [DATA_W-1:0]  alu_data_in,
  output ALUOp               alu_op,
  input  logic [DATA_W-1:0]  alu_data_out,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
`ifdef ALU_SEQ_PERF_EN
  output logic [15:0]        perf_instr_cnt,
  output logic [15:0]        perf_stall_cnt,
`endif
  output logic               busy
);

  localparam int MAX_LAT = (ADD_LATENCY > READ_LATENCY) ? ADD_LATENCY : READ_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] ADD_LOAD  = CNT_W'(ADD_LATENCY - 1);
  localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(READ_LATENCY - 1);

  SeqState             state_q, state_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [REG_AW-1:0]   addr_a_q, addr_a_d;
  logic [REG_AW-1:0]   addr_b_q, addr_b_d;
  logic [REG_AW-1:0]   addr_r_q, addr_r_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  ALUOp                op_q, op_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]    cnt_load_val;

  logic                hs;
  SeqKind              kind;
  logic [REG_AW-1:0]   f_rd, f_ra, f_rb;
  logic [DATA_W-1:0]   f_imm;

  assign hs    = instr_valid && ready_q;
  assign kind  = instr_kind(instr);
  assign f_rd  = instr[RD_LSB  +: REG_AW];
  assign f_ra  = instr[RA_LSB  +: REG_AW];
  assign f_rb  = instr[RB_LSB  +: REG_AW];
  assign f_imm = instr[IMM_LSB +: DATA_W];

  seq_latency_counter #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Outputs default to the idle op (harmless read of r0) unless a state holds them.
  always_comb begin
    state_d      = state_q;
    addr_a_d     = '0;
    addr_b_d     = '0;
    addr_r_d     = '0;
    data_in_d    = '0;
    op_d         = REG_READ;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          case (kind)
            SEQ_LOADI: begin
              state_d   = S_LOAD;
              addr_a_d  = f_rd;
              data_in_d = f_imm;
              op_d      = REG_WRITE;
            end
            SEQ_ADD: begin
              state_d      = S_ADD_WAIT;
              addr_a_d     = f_ra;
              addr_b_d     = f_rb;
              addr_r_d     = f_rd;
              op_d         = ADD;
              cnt_load     = 1'b1;
              cnt_load_val = ADD_LOAD;
            end
            SEQ_READ: begin
              state_d      = S_READ_WAIT;
              addr_a_d     = f_ra;
              op_d         = REG_READ;
              cnt_load     = 1'b1;
              cnt_load_val = READ_LOAD;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: state_d = S_IDLE;
      S_ADD_WAIT: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          addr_a_d = addr_a_q;
          addr_b_d = addr_b_q;
          addr_r_d = addr_r_q;
          op_d     = ADD;
          cnt_dec  = 1'b1;
        end
      end
      S_READ_WAIT: begin
        if (cnt_zero) begin
          state_d    = S_IDLE;
          rd_data_d  = alu_data_out;
          rd_valid_d = 1'b1;
        end else begin
          addr_a_d = addr_a_q;
          op_d     = REG_READ;
          cnt_dec  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_r_q   <= '0;
      data_in_q  <= '0;
      op_q       <= REG_READ;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_r_q   <= addr_r_d;
      data_in_q  <= data_in_d;
      op_q       <= op_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_instr_q, perf_instr_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    perf_instr_d = sat_inc(perf_instr_q, hs && (kind != SEQ_NOP));
    perf_stall_d = sat_inc(perf_stall_q, instr_valid && !ready_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_instr_cnt = perf_instr_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign alu_addr_a  = addr_a_q;
  assign alu_addr_b  = addr_b_q;
  assign alu_addr_r  = addr_r_q;
  assign alu_data_in = data_in_q;
  assign alu_op      = op_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

endmodule
